// File: rtl/slt_rs.sv
// Reservation station plus one-entry result buffer for the LUI/SLT/SLTU unit.
// Entries wait for CDB operands; the oldest ready entry is dispatched whenever the buffer can accept it.
module slt_rs #(
  parameter int DEPTH = 3,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       issue_aluc,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [TAG_W-1:0] issue_dest,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic [31:0]      fu_alu1,
  output logic [31:0]      fu_alu2,
  output logic [1:0]       fu_aluc,
  input  logic [31:0]      fu_res,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             busy;
    logic [1:0]       aluc;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic             qjb;
    logic [TAG_W-1:0] qk;
    logic             qkb;
    logic [TAG_W-1:0] dest;
    logic [CNT_W-1:0] rank;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic             outValid_q, outValid_d;
  logic [TAG_W-1:0] outTag_q, outTag_d;
  logic [31:0]      outData_q, outData_d;

  logic [CNT_W-1:0] busyCnt;
  logic [CNT_W-1:0] newRank;
  logic [IDX_W-1:0] freeIdx;
  logic             freeFound;
  logic [IDX_W-1:0] selIdx;
  logic [CNT_W-1:0] selRank;
  logic             selFound;
  logic             doDispatch;
  logic             doIssue;
  logic             bypassJ, bypassK;

  // Occupancy and lowest-index free slot, both from registered state only.
  always_comb begin
    busyCnt   = '0;
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      busyCnt = busyCnt + CNT_W'(ent_q[i].busy);
      if (!ent_q[i].busy) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    selRank  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy && !ent_q[i].qjb && !ent_q[i].qkb &&
          (!selFound || ent_q[i].rank < selRank)) begin
        selFound = 1'b1;
        selIdx   = IDX_W'(i);
        selRank  = ent_q[i].rank;
      end
    end
  end

  assign issue_ready = (busyCnt < CNT_W'(DEPTH));
  assign doDispatch  = selFound && (!outValid_q || cdb_grant);
  assign doIssue     = issue_valid && issue_ready && freeFound;
  assign newRank     = busyCnt - CNT_W'(doDispatch);
  assign bypassJ     = issue_qj_busy && cdb_valid && (cdb_tag == issue_qj);
  assign bypassK     = issue_qk_busy && cdb_valid && (cdb_tag == issue_qk);

  always_comb begin
    fu_alu1 = '0;
    fu_alu2 = '0;
    fu_aluc = '0;
    if (doDispatch) begin
      fu_alu1 = ent_q[selIdx].vj;
      fu_alu2 = ent_q[selIdx].vk;
      fu_aluc = ent_q[selIdx].aluc;
    end
  end

  // Priority per entry: wakeup/age < dispatch free < issue write < flush.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        if (ent_q[i].qjb && cdb_valid && (cdb_tag == ent_q[i].qj)) begin
          ent_d[i].vj  = cdb_data;
          ent_d[i].qjb = 1'b0;
        end
        if (ent_q[i].qkb && cdb_valid && (cdb_tag == ent_q[i].qk)) begin
          ent_d[i].vk  = cdb_data;
          ent_d[i].qkb = 1'b0;
        end
        if (doDispatch && (ent_q[i].rank > selRank)) begin
          ent_d[i].rank = ent_q[i].rank - CNT_W'(1);
        end
      end
      if (doDispatch && (selIdx == IDX_W'(i))) begin
        ent_d[i].busy = 1'b0;
        ent_d[i].rank = '0;
      end
      if (doIssue && (freeIdx == IDX_W'(i))) begin
        ent_d[i].busy = 1'b1;
        ent_d[i].aluc = issue_aluc;
        ent_d[i].vj   = bypassJ ? cdb_data : issue_vj;
        ent_d[i].vk   = bypassK ? cdb_data : issue_vk;
        ent_d[i].qj   = issue_qj;
        ent_d[i].qk   = issue_qk;
        ent_d[i].qjb  = issue_qj_busy && !bypassJ;
        ent_d[i].qkb  = issue_qk_busy && !bypassK;
        ent_d[i].dest = issue_dest;
        ent_d[i].rank = newRank;
      end
      if (flush) begin
        ent_d[i].busy = 1'b0;
        ent_d[i].rank = '0;
      end
    end
  end

  // A grant alone drains the buffer; a dispatch refills it in the same edge.
  always_comb begin
    outValid_d = outValid_q;
    outTag_d   = outTag_q;
    outData_d  = outData_q;
    if (doDispatch) begin
      outValid_d = 1'b1;
      outTag_d   = ent_q[selIdx].dest;
      outData_d  = fu_res;
    end else if (cdb_grant) begin
      outValid_d = 1'b0;
    end
    if (flush) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      outValid_q <= 1'b0;
      outTag_q   <= '0;
      outData_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      outValid_q <= outValid_d;
      outTag_q   <= outTag_d;
      outData_q  <= outData_d;
    end
  end

  assign cdb_req  = outValid_q;
  assign out_tag  = outTag_q;
  assign out_data = outData_q;

endmodule
